ram_ecc_ctrl_8x72: RTL

SECDED front-end controller placed directly upstream of the 8x72 flop RAM. It accepts 64-bit read/write requests over a valid/ready handshake. On writes it encodes the data to a 72-bit Hamming(72,64) codeword and drives the RAM write port. On reads it fetches the codeword, corrects single-bit errors, flags double-bit errors, and returns the data over a valid/ready response channel.

---
 rtl/ram_ecc_pkg.sv | 58 +++++
 rtl/ecc_secded_dec_72_64.sv | 47 ++++
 rtl/ram_ecc_ctrl_8x72.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ram_ecc_pkg.sv
// Shared constants, FSM states and the Hamming(72,64) layout/encoder for the 8x72 ECC controller.
// Codeword position p (1..71) lives at bit p-1; check bits at powers of two; bit 71 is overall parity.
package ram_ecc_pkg;

  localparam int DATA_W = 64;
  localparam int CODE_W = DATA_W + 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    CHK   = 3'd3,
    RSP   = 3'd4,
    SCRUB = 3'd5
  } state_t;

  function automatic logic is_chk_pos(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Codeword position (1-based) of data bit j; data fills non-power-of-two slots ascending.
  function automatic int data_pos(input int j);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int p = 3; p < CODE_W; p++) begin
      if (!is_chk_pos(p)) begin
        if (n == j) pos = p;
        n++;
      end
    end
    return pos;
  endfunction

  function automatic logic [CODE_W-1:0] secded_enc(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] cw;
    logic              b;
    cw = '0;
    b  = 1'b0;
    for (int j = 0; j < DATA_W; j++) begin
      cw[IDX_W'(data_pos(j) - 1)] = d[j];
    end
    for (int i = 0; i < IDX_W; i++) begin
      b = 1'b0;
      for (int p = 1; p < CODE_W; p++) begin
        if ((((p >> i) & 1) == 1) && (p != (1 << i))) b = b ^ cw[IDX_W'(p - 1)];
      end
      cw[IDX_W'((1 << i) - 1)] = b;
    end
    cw[CODE_W-1] = ^cw[CODE_W-2:0];
    return cw;
  endfunction

endpackage

// File: rtl/ecc_secded_dec_72_64.sv
// Combinational SECDED decoder: corrects any single-bit error, flags double errors and
// syndromes that point past the codeword. On DED the data bits are passed through raw.
module ecc_secded_dec_72_64
  import ram_ecc_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [DATA_W-1:0] data,
  output logic              sec,
  output logic              ded
);

  logic [IDX_W-1:0]  syn;
  logic              par;
  logic [CODE_W-1:0] fixed;

  always_comb begin
    syn   = '0;
    par   = ^code;
    fixed = code;
    sec   = 1'b0;
    ded   = 1'b0;
    data  = '0;

    for (int p = 1; p < CODE_W; p++) begin
      if (code[IDX_W'(p - 1)]) syn = syn ^ IDX_W'(p);
    end

    if (par) begin
      if (syn == '0) begin
        // Only the overall parity bit flipped; payload is intact.
        sec = 1'b1;
      end else if (syn <= IDX_W'(CODE_W - 1)) begin
        fixed[syn - IDX_W'(1)] = ~fixed[syn - IDX_W'(1)];
        sec = 1'b1;
      end else begin
        ded = 1'b1;
      end
    end else if (syn != '0) begin
      ded = 1'b1;
    end

    for (int j = 0; j < DATA_W; j++) begin
      data[j] = fixed[IDX_W'(data_pos(j) - 1)];
    end
  end

endmodule

// File: rtl/ram_ecc_ctrl_8x72.sv
// SECDED front-end for the 8x72 RAM: write commits one cycle after accept, read response 2 cycles after accept,
// held until rsp_ready; req_ready only in IDLE. `define ECC_SCRUB_EN to write corrected words back after a SEC read.
module ram_ecc_ctrl_8x72
  import ram_ecc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_sec,
  output logic              rsp_ded,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_address,
  output logic [CODE_W-1:0] ram_wdata,
  input  logic [CODE_W-1:0] ram_rdata
);

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] dec_data;
  logic              dec_sec;
  logic              dec_ded;
`ifdef ECC_SCRUB_EN
  logic              scrub_pend;
`endif

  ecc_secded_dec_72_64 u_dec (
    .code (ram_rdata),
    .data (dec_data),
    .sec  (dec_sec),
    .ded  (dec_ded)
  );

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req_valid) next_state = req_we ? WR : RD;
      WR:   next_state = IDLE;
      RD:   next_state = CHK;
      CHK:  next_state = RSP;
      RSP: begin
        if (rsp_ready) begin
`ifdef ECC_SCRUB_EN
          next_state = scrub_pend ? SCRUB : IDLE;
`else
          next_state = IDLE;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_sec     <= 1'b0;
      rsp_ded     <= 1'b0;
      err_cnt     <= '0;
      ram_wr      <= 1'b0;
      ram_address <= '0;
      ram_wdata   <= '0;
`ifdef ECC_SCRUB_EN
      scrub_pend  <= 1'b0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      ram_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            ram_address <= req_addr;
            if (req_we) begin
              ram_wr    <= 1'b1;
              ram_wdata <= secded_enc(req_wdata);
            end
          end
        end
        CHK: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= dec_data;
          rsp_sec   <= dec_sec;
          rsp_ded   <= dec_ded;
          if (dec_sec && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
`ifdef ECC_SCRUB_EN
          scrub_pend <= dec_sec;
`endif
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef ECC_SCRUB_EN
            if (scrub_pend) begin
              ram_wr    <= 1'b1;
              ram_wdata <= secded_enc(rsp_rdata);
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
